// File: rtl/ram_iir_inverse.sv
// ram_iir_inverse: time-multiplexed all-pole IIR y[n] = x[n] - sum a[k]*y[n-k]; history in RAM, a[k] in ROM (COEFFS, entry k at [k*DW +: DW]).
// Define RAM_IIR_INVERSE_SAT_EN to saturate y to DW bits; by default y wraps.
module ram_iir_inverse #(
  parameter int DW = 16,
  parameter int LEN = 8,
  parameter int COEFF_FRAC = 15,
  parameter string COEFFS_FILE = "none.mem",
  parameter string RAMSTYLE = "M9K",
  parameter logic [LEN*DW-1:0] COEFFS = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sample_valid_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          data_valid_o,
  output logic          busy_o,
  output logic          overrun_o
);
  localparam int AW = $clog2(LEN);
  localparam int DEPTH = 1 << AW;
  localparam int PW = 2 * DW;
  localparam int ACW = PW + AW + 1;
  localparam int YW = DW + AW + 2;
  typedef enum logic [2:0] {CLEAR, IDLE, RUN, DRAIN, OUTPUT} state_t;
  state_t state_q;
  logic [AW-1:0] ptr_q, cnt_q;
  logic [DW-1:0] x_q, data_q, y_d;
  logic signed [DW-1:0] ram_q, rom_q;
  logic signed [PW-1:0] prod_q;
  logic signed [ACW-1:0] acc_q;
  logic rd_v_q, prod_v_q, valid_q, busy_q, overrun_q;
  logic [DW-1:0] rom [DEPTH];
  (* ramstyle = RAMSTYLE *) logic [DW-1:0] mem [DEPTH];
  logic mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  if (LEN < 2 || COEFFS_FILE == "" || RAMSTYLE == "") begin : g_bad
    $error("ram_iir_inverse: LEN must be >= 2 and file/style names must be non-empty");
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    if (i < LEN) begin : g_tap
      assign rom[i] = COEFFS[i*DW +: DW];
    end else begin : g_pad
      assign rom[i] = '0;
    end
  end

`ifdef RAM_IIR_INVERSE_SAT_EN
  logic [YW-1:0] y_full;
  assign y_full = {{(YW-DW){x_q[DW-1]}}, x_q} - YW'(acc_q >>> COEFF_FRAC);
  // in range only when all bits above the DW-bit sign agree with it
  assign y_d = (&y_full[YW-1:DW-1] || ~|y_full[YW-1:DW-1]) ? y_full[DW-1:0]
             : {y_full[YW-1], {(DW-1){~y_full[YW-1]}}};
`else
  assign y_d = x_q - DW'(acc_q >>> COEFF_FRAC);
`endif

  // newest output goes just below ptr, so ptr+k-1 always holds y[n-k]
  assign mem_we = state_q == CLEAR || state_q == OUTPUT;
  assign mem_wa = state_q == CLEAR ? cnt_q : ptr_q - AW'(1);
  assign mem_wd = state_q == CLEAR ? '0 : y_d;

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    ram_q <= mem[ptr_q + cnt_q];
    rom_q <= rom[cnt_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      rd_v_q    <= 1'b0;
      prod_v_q  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      rd_v_q    <= state_q == RUN;
      prod_v_q  <= rd_v_q;
      prod_q    <= PW'(ram_q) * PW'(rom_q);
      acc_q     <= state_q == OUTPUT ? '0
                 : prod_v_q ? acc_q + $signed({{(ACW-PW){prod_q[PW-1]}}, prod_q}) : acc_q;
      valid_q   <= state_q == OUTPUT;
      overrun_q <= sample_valid_i && state_q != IDLE;
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + AW'(1);
          if (&cnt_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: if (sample_valid_i) begin
          x_q     <= data_i;
          cnt_q   <= '0;
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: begin
          cnt_q <= cnt_q == AW'(LEN-1) ? '0 : cnt_q + AW'(1);
          if (cnt_q == AW'(LEN-1)) state_q <= DRAIN;
        end
        DRAIN: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(1)) state_q <= OUTPUT;
        end
        OUTPUT: begin
          data_q  <= y_d;
          ptr_q   <= ptr_q - AW'(1);
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_ram_iir_inverse.sv
// tb_ram_iir_inverse: directed checks of ram_iir_inverse with a LEN=4 instance (a1=-0.5) and a LEN=8 instance (a1=-0.25, a2=0.125, a8=0.0625).
module tb_ram_iir_inverse;
  logic clk, rst;
  logic sv0, v0, b0, o0, sv1, v1, b1, o1;
  logic [15:0] d0, q0, d1, q1;
  int n_chk = 0, n_fail = 0;
  int c0, c1, y, lat, n_ovr, ovr_at;
  int imp_x[4] = '{16384, 0, 0, 0};
  int imp_y[4] = '{16384, 8192, 4096, 2048};
`ifdef RAM_IIR_INVERSE_SAT_EN
  int sat_y[4] = '{20000, 30000, 32767, 32767};
`else
  int sat_y[4] = '{20000, 30000, -30536, 4732};
`endif
  int a8[9] = '{0, -8192, 4096, 0, 0, 0, 0, 0, 2048};
  int xs[30], vs[30], ym[30];

  ram_iir_inverse #(.DW(16), .LEN(4), .COEFF_FRAC(15), .COEFFS({48'h0, 16'hC000})) u0 (
    .clk_i(clk), .rst_i(rst), .sample_valid_i(sv0), .data_i(d0),
    .data_o(q0), .data_valid_o(v0), .busy_o(b0), .overrun_o(o0));
  ram_iir_inverse #(.DW(16), .LEN(8), .COEFF_FRAC(15), .COEFFS({16'h0800, 80'h0, 16'h1000, 16'hE000})) u1 (
    .clk_i(clk), .rst_i(rst), .sample_valid_i(sv1), .data_i(d1),
    .data_o(q1), .data_valid_o(v1), .busy_o(b1), .overrun_o(o1));

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic count_clear();
    c0 = 0;
    c1 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (!b0 && c0 == 0) c0 = i;
      if (!b1 && c1 == 0) c1 = i;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    count_clear();
  endtask

  task automatic send0(input int x, output int yo, output int lo);
    @(negedge clk);
    d0 = 16'(x);
    sv0 = 1;
    @(negedge clk);
    sv0 = 0;
    lo = 0;
    while (!v0 && lo < 40) begin
      @(negedge clk);
      lo++;
    end
    yo = int'($signed(q0));
    repeat (12) @(negedge clk);
  endtask

  initial begin
    longint sf, sm;
    rst = 1; sv0 = 0; sv1 = 0; d0 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", int'($signed(q0)), 0);
    chk("rst_valid", int'(v0), 0);
    chk("rst_busy", int'(b0), 1);
    chk("rst_ovr", int'(o0), 0);
    do_reset();
    chk("clear_len4", c0, 4);
    chk("clear_len8", c1, 8);

    for (int i = 0; i < 4; i++) begin
      send0(imp_x[i], y, lat);
      chk("imp_y", y, imp_y[i]);
      chk("imp_lat", lat, 7);
    end

    // second strobe lands three cycles into the first computation
    @(negedge clk);
    d0 = 16'd1000;
    sv0 = 1;
    lat = -1; n_ovr = 0; ovr_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sv0 = (i == 2);
      if (i == 2) d0 = 16'd5000;
      if (o0) begin n_ovr++; ovr_at = i; end
      if (v0 && lat < 0) begin lat = i; y = int'($signed(q0)); end
    end
    chk("ovr_count", n_ovr, 1);
    chk("ovr_cycle", ovr_at, 3);
    chk("ovr_lat", lat, 7);
    chk("ovr_y", y, 2024);

    @(negedge clk);
    d0 = 16'd3000;
    sv0 = 1;
    @(negedge clk);
    sv0 = 0;
    @(negedge clk);
    chk("pre_rst_data", int'($signed(q0)), 2024);
    rst = 1;
    #1;
    chk("mid_rst_data", int'($signed(q0)), 0);
    chk("mid_rst_busy", int'(b0), 1);
    chk("mid_rst_valid", int'(v0), 0);
    @(negedge clk);
    rst = 0;
    count_clear();
    chk("mid_clear_len4", c0, 4);
    send0(16384, y, lat);
    chk("post_rst_y", y, 16384);
    chk("post_rst_lat", lat, 7);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      send0(20000, y, lat);
      chk("sat_y", y, sat_y[i]);
    end

    for (int n = 0; n < 30; n++) begin
      xs[n] = ((n * 37) % 29 - 14) * 256;
      sf = 0;
      sm = 0;
      for (int k = 1; k <= 8; k++) if (n - k >= 0) begin
        sf += longint'(a8[k]) * xs[n-k];
        sm += longint'(a8[k]) * ym[n-k];
      end
      vs[n] = xs[n] + int'(sf >>> 15);
      ym[n] = vs[n] - int'(sm >>> 15);
    end
    n_ovr = 0;
    @(negedge clk);
    d1 = 16'(vs[0]);
    sv1 = 1;
    for (int n = 0; n < 30; n++) begin
      lat = -1;
      y = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        sv1 = 0;
        if (o1) n_ovr++;
        if (v1 && lat < 0) begin lat = i; y = int'($signed(q1)); end
        if (i == 11 && n < 29) begin
          d1 = 16'(vs[n+1]);
          sv1 = 1;
        end
      end
      chk("wrap_lat", lat, 11);
      chk("wrap_y", y, ym[n]);
      chk("round_trip", int'(y - xs[n] <= 1 && xs[n] - y <= 1), 1);
    end
    chk("wrap_ovr", n_ovr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
